prime_logger: RTL and testbench

//  Sits directly downstream of the prime-search stage. Watches its NumberChecked/Prime outputs,

---
 rtl/prime_logger.sv | 188 ++++++++++++++++++
 tb/tb_prime_logger.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prime_logger.sv
// Logs each newly reported prime from the search stage into a FIFO and drains it over valid/ready.
// Define PRIME_LOGGER_BCD_EN to add the serial binary-to-BCD converter that drives OutBCD.
module prime_logger #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          SysClk,
  input  logic          Reset,
  input  logic [9:0]    NumberChecked,
  input  logic          Prime,
  input  logic          Clear,
  input  logic          OutReady,
  output logic          OutValid,
  output logic [9:0]    OutPrime,
  output logic [11:0]   OutBCD,
  output logic [AW:0]   Count,
  output logic          Full,
  output logic          Overflow,
  output logic [7:0]    Dropped
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
`ifdef PRIME_LOGGER_BCD_EN
  localparam logic [1:0] CONV = 2'd2;
`endif
  localparam logic [1:0] HOLD = 2'd3;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [9:0]    last_seen;
  logic          last_valid;
  logic [9:0]    pop_data;
  logic [1:0]    state;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop;

  assign Full = (Count == (AW+1)'(DEPTH));

  // A prime held on the input for many cycles must only be logged once.
  assign push   = Prime & (~last_valid | (NumberChecked != last_seen));
  assign pop    = ~Clear & (Count != '0) & ((state == IDLE) | ((state == HOLD) & OutReady));
  assign accept = push & ~Clear & (~Full | pop);
  assign drop   = push & ~Clear & Full & ~pop;

  always_ff @(posedge SysClk) begin
    if (accept)
      mem[wr_ptr] <= NumberChecked;
  end

  always_ff @(posedge SysClk) begin
    if (pop)
      pop_data <= mem[rd_ptr];
  end

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      last_seen  <= '0;
      last_valid <= 1'b0;
    end else if (Clear) begin
      last_seen  <= '0;
      last_valid <= 1'b0;
    end else if (push) begin
      last_seen  <= NumberChecked;
      last_valid <= 1'b1;
    end
  end

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
      Dropped  <= '0;
    end else if (Clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
      Dropped  <= '0;
    end else begin
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   Count <= Count + (AW+1)'(1);
        2'b01:   Count <= Count - (AW+1)'(1);
        default: Count <= Count;
      endcase
      if (drop) begin
        Overflow <= 1'b1;
        if (Dropped != 8'hFF)
          Dropped <= Dropped + 8'd1;
      end
    end
  end

`ifdef PRIME_LOGGER_BCD_EN
  logic [21:0] dabble;
  logic [21:0] adj;
  logic [21:0] dabble_next;
  logic [3:0]  bit_cnt;
  logic [11:0] bcd_q;

  // Add-3 correction on every BCD digit of 5 or more, then shift one binary bit in.
  always_comb begin
    adj = dabble;
    if (adj[13:10] > 4'd4) adj[13:10] = adj[13:10] + 4'd3;
    if (adj[17:14] > 4'd4) adj[17:14] = adj[17:14] + 4'd3;
    if (adj[21:18] > 4'd4) adj[21:18] = adj[21:18] + 4'd3;
    dabble_next = adj << 1;
  end

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      dabble  <= '0;
      bit_cnt <= '0;
      bcd_q   <= '0;
    end else if (Clear) begin
      dabble  <= '0;
      bit_cnt <= '0;
      bcd_q   <= '0;
    end else if (state == LOAD) begin
      dabble  <= {12'h000, pop_data};
      bit_cnt <= '0;
    end else if (state == CONV) begin
      dabble  <= dabble_next;
      bit_cnt <= bit_cnt + 4'd1;
      if (bit_cnt == 4'd9)
        bcd_q <= dabble_next[21:10];
    end
  end

  assign OutBCD = bcd_q;
`else
  assign OutBCD = 12'h000;
`endif

  always_ff @(posedge SysClk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      OutPrime <= '0;
    end else if (Clear) begin
      state    <= IDLE;
      OutValid <= 1'b0;
      OutPrime <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop)
            state <= LOAD;
        end
        LOAD: begin
          OutPrime <= pop_data;
`ifdef PRIME_LOGGER_BCD_EN
          state    <= CONV;
`else
          state    <= HOLD;
          OutValid <= 1'b1;
`endif
        end
`ifdef PRIME_LOGGER_BCD_EN
        CONV: begin
          if (bit_cnt == 4'd9) begin
            state    <= HOLD;
            OutValid <= 1'b1;
          end
        end
`endif
        HOLD: begin
          // The next entry is already popped in the handshake cycle to sustain throughput.
          if (OutReady) begin
            OutValid <= 1'b0;
            state    <= pop ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prime_logger.sv
// Scoreboard bench for prime_logger: a capacity-based capture model feeds an expected queue,
// and a negedge monitor checks every handshake against it.
module tb_prime_logger;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef PRIME_LOGGER_BCD_EN
  localparam int LATENCY = 13;
`else
  localparam int LATENCY = 3;
`endif

  logic          SysClk = 1'b0;
  logic          Reset = 1'b0;
  logic [9:0]    NumberChecked = '0;
  logic          Prime = 1'b0;
  logic          Clear = 1'b0;
  logic          OutReady = 1'b0;
  logic          OutValid;
  logic [9:0]    OutPrime;
  logic [11:0]   OutBCD;
  logic [AW:0]   Count;
  logic          Full;
  logic          Overflow;
  logic [7:0]    Dropped;

  int testsRun = 0;
  int testsFailed = 0;
  int outputsSeen = 0;

  logic [9:0] expQ[$];
  logic [9:0] modelLast = '0;
  bit         modelLastValid = 1'b0;
  int         modelDropped = 0;
  bit         modelOverflow = 1'b0;
  logic [9:0] monExp;

  prime_logger #(.DEPTH(DEPTH), .AW(AW)) dut (
    .SysClk(SysClk), .Reset(Reset), .NumberChecked(NumberChecked), .Prime(Prime),
    .Clear(Clear), .OutReady(OutReady), .OutValid(OutValid), .OutPrime(OutPrime),
    .OutBCD(OutBCD), .Count(Count), .Full(Full), .Overflow(Overflow), .Dropped(Dropped)
  );

  always #5 SysClk = ~SysClk;

  function automatic int expBcd(input logic [9:0] v);
`ifdef PRIME_LOGGER_BCD_EN
    int x;
    x = int'(v);
    return ((x / 100) << 8) | (((x / 10) % 10) << 4) | (x % 10);
`else
    return (v == 10'd1023) ? 0 : 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every handshake must match the oldest expected entry.
  always @(negedge SysClk) begin
    if (!Reset && !Clear && OutValid && OutReady) begin
      outputsSeen++;
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected output: got %0d, expected no entry", OutPrime);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("OutPrime", int'(OutPrime), int'(monExp));
        checkOutput("OutBCD", int'(OutBCD), expBcd(monExp));
      end
    end
  end

  // One clock of stimulus; the model decides after the monitor has retired this edge's handshake.
  task automatic applyStimulus(input bit prime, input logic [9:0] num, input bit ready, input bit clear);
    @(posedge SysClk);
    #1;
    Prime = prime;
    NumberChecked = num;
    OutReady = ready;
    Clear = clear;
    @(negedge SysClk);
    #1;
    if (clear) begin
      expQ.delete();
      modelLastValid = 1'b0;
      modelDropped = 0;
      modelOverflow = 1'b0;
    end else if (prime && (!modelLastValid || num != modelLast)) begin
      modelLast = num;
      modelLastValid = 1'b1;
      if (expQ.size() < DEPTH + 1)
        expQ.push_back(num);
      else begin
        modelOverflow = 1'b1;
        if (modelDropped < 255)
          modelDropped++;
      end
    end
  endtask

  task automatic doReset();
    @(posedge SysClk);
    #1;
    Reset = 1'b1;
    Prime = 1'b0;
    Clear = 1'b0;
    OutReady = 1'b0;
    repeat (2) @(posedge SysClk);
    #1;
    Reset = 1'b0;
    expQ.delete();
    modelLastValid = 1'b0;
    modelDropped = 0;
    modelOverflow = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 1000 && expQ.size() != 0; i++)
      applyStimulus(1'b0, NumberChecked, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, NumberChecked, 1'b1, 1'b0);
    checkOutput({name, " drained"}, expQ.size(), 0);
    checkOutput({name, " count after drain"}, int'(Count), 0);
  endtask

  task automatic measureLatency(input string name, input logic [9:0] num, input int primeCycles);
    int lat;
    int seenBefore;
    lat = -1;
    seenBefore = outputsSeen;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(i <= primeCycles, num, 1'b1, 1'b0);
      if (OutValid && lat < 0) begin
        lat = i - 1;
        checkOutput({name, " OutPrime"}, int'(OutPrime), int'(num));
        checkOutput({name, " OutBCD"}, int'(OutBCD), expBcd(num));
      end
    end
    checkOutput({name, " latency"}, lat, LATENCY);
    checkOutput({name, " entries logged"}, outputsSeen - seenBefore, 1);
    checkOutput({name, " count"}, int'(Count), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int vals[5];
    bit p;
    bit r;
    bit c;
    logic [9:0] n;
    vals = '{2, 3, 5, 7, 11};

    #1 Reset = 1'b1;
    #20;
    checkOutput("reset OutValid", int'(OutValid), 0);
    checkOutput("reset OutPrime", int'(OutPrime), 0);
    checkOutput("reset OutBCD", int'(OutBCD), 0);
    checkOutput("reset Count", int'(Count), 0);
    checkOutput("reset Full", int'(Full), 0);
    checkOutput("reset Overflow", int'(Overflow), 0);
    checkOutput("reset Dropped", int'(Dropped), 0);
    #3 Reset = 1'b0;

    // Held prime logged once
    measureLatency("t1", 10'd7, 5);

    // In-order streaming with a stalled consumer
    doReset();
    foreach (vals[k])
      repeat (2) applyStimulus(1'b1, 10'(vals[k]), 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 10'd11, 1'b0, 1'b0);
    checkOutput("t2 count", int'(Count), 4);
    drain("t2");

    // Overflow with 18 distinct values
    doReset();
    for (int k = 0; k < 18; k++)
      applyStimulus(1'b1, 10'(100 + 2 * k), 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 10'd134, 1'b0, 1'b0);
    checkOutput("t3 count", int'(Count), 16);
    checkOutput("t3 full", int'(Full), 1);
    checkOutput("t3 overflow", int'(Overflow), 1);
    checkOutput("t3 dropped", int'(Dropped), 1);

    // Push and handshake pop in the same cycle while full
    applyStimulus(1'b1, 10'd500, 1'b1, 1'b0);
    applyStimulus(1'b0, 10'd500, 1'b0, 1'b0);
    checkOutput("t4 count", int'(Count), 16);
    checkOutput("t4 dropped", int'(Dropped), modelDropped);
    checkOutput("t4 overflow", int'(Overflow), int'(modelOverflow));
    drain("t4");

    doReset();
    measureLatency("t5", 10'd997, 1);

    // Async reset mid-conversion, then clear with a simultaneous push
    doReset();
    applyStimulus(1'b1, 10'd997, 1'b0, 1'b0);
    repeat (6) applyStimulus(1'b0, 10'd997, 1'b0, 1'b0);
    #2 Reset = 1'b1;
    #1;
    checkOutput("t6 OutValid", int'(OutValid), 0);
    checkOutput("t6 OutPrime", int'(OutPrime), 0);
    checkOutput("t6 OutBCD", int'(OutBCD), 0);
    checkOutput("t6 Count", int'(Count), 0);
    expQ.delete();
    modelLastValid = 1'b0;
    @(posedge SysClk);
    #1 Reset = 1'b0;
    applyStimulus(1'b1, 10'd997, 1'b0, 1'b1);
    repeat (3) applyStimulus(1'b0, 10'd997, 1'b1, 1'b0);
    checkOutput("t6 clear count", int'(Count), 0);
    checkOutput("t6 clear OutValid", int'(OutValid), 0);
    measureLatency("t6 repush", 10'd997, 1);

    // Randomized traffic, kept below capacity so nothing is dropped
    doReset();
    for (int i = 0; i < 800; i++) begin
      p = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0)
        n = 10'd0;
      else if ($urandom_range(0, 1) == 0)
        n = NumberChecked;
      else
        n = 10'($urandom_range(0, 1023));
      r = ($urandom_range(0, 9) < 6);
      c = ($urandom_range(0, 149) == 0);
      if (p && !c && (!modelLastValid || n != modelLast) && expQ.size() >= DEPTH - 1)
        p = 1'b0;
      applyStimulus(p, n, r, c);
    end
    drain("rand");
    checkOutput("rand dropped", int'(Dropped), modelDropped);
    checkOutput("rand overflow", int'(Overflow), int'(modelOverflow));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
